// File: rtl/tl_addr_demux.sv
// tl_addr_demux
//   TileLink-UL 1-to-N address demultiplexer sitting in front of the denial
//   slave. Master A requests are routed to the lowest-indexed slave whose
//   address window matches. Requests that match no window go to port N_SLV,
//   the denial port. Slave D responses are merged back to the master through
//   a round-robin arbiter. Multi-beat Put bursts (A) and multi-beat
//   AccessAckData bursts (D) are kept atomic.
//
// Ports
//   demux_clock_i, demux_reset_i : clock, synchronous active-high reset
//   m_a_*                         : master A channel (request in, ready out)
//   m_d_*                         : master D channel (response out, ready in)
//   s_a_*                         : slave A channel; payload is broadcast,
//                                   s_a_valid is one-hot over N_SLV+1 ports
//   s_d_*                         : slave D channels, flattened with port j
//                                   at [j*W +: W]; s_d_ready is one-hot
module tl_addr_demux #(
  parameter int unsigned TL_RS = 1,
  parameter int unsigned TL_AW = 32,
  parameter int unsigned TL_DW = 32,
  parameter int unsigned N_SLV = 2,
  parameter logic [N_SLV*TL_AW-1:0] SLV_BASE = '0,
  parameter logic [N_SLV*TL_AW-1:0] SLV_MASK = '0
) (
  input  logic                         demux_clock_i,
  input  logic                         demux_reset_i,

  input  logic [2:0]                   m_a_opcode,
  input  logic [2:0]                   m_a_param,
  input  logic [2:0]                   m_a_size,
  input  logic [TL_RS-1:0]             m_a_source,
  input  logic [TL_AW-1:0]             m_a_address,
  input  logic [TL_DW/8-1:0]           m_a_mask,
  input  logic [TL_DW-1:0]             m_a_data,
  input  logic                         m_a_corrupt,
  input  logic                         m_a_valid,
  output logic                         m_a_ready,

  output logic [2:0]                   m_d_opcode,
  output logic [1:0]                   m_d_param,
  output logic [2:0]                   m_d_size,
  output logic [TL_RS-1:0]             m_d_source,
  output logic                         m_d_denied,
  output logic [TL_DW-1:0]             m_d_data,
  output logic                         m_d_corrupt,
  output logic                         m_d_valid,
  input  logic                         m_d_ready,

  output logic [2:0]                   s_a_opcode,
  output logic [2:0]                   s_a_param,
  output logic [2:0]                   s_a_size,
  output logic [TL_RS-1:0]             s_a_source,
  output logic [TL_AW-1:0]             s_a_address,
  output logic [TL_DW/8-1:0]           s_a_mask,
  output logic [TL_DW-1:0]             s_a_data,
  output logic                         s_a_corrupt,
  output logic [N_SLV:0]               s_a_valid,
  input  logic [N_SLV:0]               s_a_ready,

  input  logic [(N_SLV+1)*3-1:0]       s_d_opcode,
  input  logic [(N_SLV+1)*2-1:0]       s_d_param,
  input  logic [(N_SLV+1)*3-1:0]       s_d_size,
  input  logic [(N_SLV+1)*TL_RS-1:0]   s_d_source,
  input  logic [N_SLV:0]               s_d_denied,
  input  logic [(N_SLV+1)*TL_DW-1:0]   s_d_data,
  input  logic [N_SLV:0]               s_d_corrupt,
  input  logic [N_SLV:0]               s_d_valid,
  output logic [N_SLV:0]               s_d_ready
);

  localparam int unsigned NP = N_SLV + 1;
  localparam int unsigned GW = (NP > 1) ? $clog2(NP) : 1;
  localparam int unsigned L  = $clog2(TL_DW / 8);
  localparam logic [2:0]  LW = 3'(L);

  // Number of data beats carried by a message of the given size.
  function automatic logic [7:0] beats_of(input logic [2:0] size);
    if (size > LW) return 8'd1 << (size - LW);
    return 8'd1;
  endfunction

  // ---------------------------------------------------------------- A side
  logic          a_lock;
  logic [7:0]    a_cnt;
  logic [GW-1:0] a_tgt;
  logic [GW-1:0] dec_idx;
  logic [GW-1:0] a_sel;
  logic          hit_found;
  logic          a_hs;
  logic          a_put;
  logic [7:0]    a_beats;

  always_comb begin
    dec_idx   = GW'(N_SLV);
    hit_found = 1'b0;
    for (int unsigned i = 0; i < N_SLV; i++) begin
      if (!hit_found &&
          ((m_a_address & SLV_MASK[i*TL_AW +: TL_AW]) == SLV_BASE[i*TL_AW +: TL_AW])) begin
        hit_found = 1'b1;
        dec_idx   = GW'(i);
      end
    end
  end

  assign a_sel = a_lock ? a_tgt : dec_idx;

  always_comb begin
    s_a_valid = '0;
    m_a_ready = 1'b0;
    for (int unsigned j = 0; j < NP; j++) begin
      if (a_sel == GW'(j)) begin
        s_a_valid[j] = m_a_valid;
        m_a_ready    = s_a_ready[j];
      end
    end
    if (demux_reset_i) begin
      s_a_valid = '0;
      m_a_ready = 1'b0;
    end
  end

  assign s_a_opcode  = m_a_opcode;
  assign s_a_param   = m_a_param;
  assign s_a_size    = m_a_size;
  assign s_a_source  = m_a_source;
  assign s_a_address = m_a_address;
  assign s_a_mask    = m_a_mask;
  assign s_a_data    = m_a_data;
  assign s_a_corrupt = m_a_corrupt;

  assign a_hs    = m_a_valid && m_a_ready;
  assign a_put   = (m_a_opcode == 3'd0) || (m_a_opcode == 3'd1);
  assign a_beats = beats_of(m_a_size);

  // ---------------------------------------------------------------- D side
  logic          d_lock;
  logic [7:0]    d_cnt;
  logic          d_hold;
  logic [GW-1:0] rr;
  logic [GW-1:0] d_gnt;      // grant registered from the previous cycle
  logic [GW-1:0] arb_idx;
  logic          arb_found;
  logic [GW-1:0] d_sel;      // grant in effect this cycle
  logic [GW-1:0] rr_next;
  logic          d_hs;
  logic [7:0]    d_beats;
  logic          d_first_burst;
  logic          d_last;

  // Rotating priority in two passes: ports at or above rr first, then wrap.
  always_comb begin
    arb_idx   = rr;
    arb_found = 1'b0;
    for (int unsigned j = 0; j < NP; j++) begin
      if (!arb_found && (GW'(j) >= rr) && s_d_valid[j]) begin
        arb_found = 1'b1;
        arb_idx   = GW'(j);
      end
    end
    for (int unsigned j = 0; j < NP; j++) begin
      if (!arb_found && s_d_valid[j]) begin
        arb_found = 1'b1;
        arb_idx   = GW'(j);
      end
    end
  end

  // A stalled response or a burst in progress keeps the previous grant so the
  // presented payload cannot switch underneath the master.
  assign d_sel = (d_lock || d_hold) ? d_gnt : arb_idx;

  always_comb begin
    m_d_opcode  = '0;
    m_d_param   = '0;
    m_d_size    = '0;
    m_d_source  = '0;
    m_d_denied  = 1'b0;
    m_d_data    = '0;
    m_d_corrupt = 1'b0;
    m_d_valid   = 1'b0;
    s_d_ready   = '0;
    for (int unsigned j = 0; j < NP; j++) begin
      if (d_sel == GW'(j)) begin
        m_d_opcode   = s_d_opcode[j*3 +: 3];
        m_d_param    = s_d_param[j*2 +: 2];
        m_d_size     = s_d_size[j*3 +: 3];
        m_d_source   = s_d_source[j*TL_RS +: TL_RS];
        m_d_denied   = s_d_denied[j];
        m_d_data     = s_d_data[j*TL_DW +: TL_DW];
        m_d_corrupt  = s_d_corrupt[j];
        m_d_valid    = s_d_valid[j];
        s_d_ready[j] = m_d_ready;
      end
    end
    if (demux_reset_i) begin
      m_d_valid = 1'b0;
      s_d_ready = '0;
    end
  end

  assign d_hs          = m_d_valid && m_d_ready;
  assign d_beats       = beats_of(m_d_size);
  assign d_first_burst = !d_lock && (m_d_opcode == 3'd1) && (d_beats > 8'd1);
  assign d_last        = d_lock ? (d_cnt == 8'd1) : !d_first_burst;
  assign rr_next       = (d_sel == GW'(N_SLV)) ? '0 : d_sel + GW'(1);

  // ------------------------------------------------------------ state
  always_ff @(posedge demux_clock_i) begin
    if (demux_reset_i) begin
      a_lock <= 1'b0;
      a_cnt  <= '0;
      a_tgt  <= '0;
      d_lock <= 1'b0;
      d_cnt  <= '0;
      d_hold <= 1'b0;
      rr     <= '0;
      d_gnt  <= '0;
    end else begin
      if (a_hs) begin
        if (a_lock) begin
          a_cnt <= a_cnt - 8'd1;
          if (a_cnt == 8'd1) a_lock <= 1'b0;
        end else if (a_put && (a_beats > 8'd1)) begin
          a_lock <= 1'b1;
          a_tgt  <= dec_idx;
          a_cnt  <= a_beats - 8'd1;
        end
      end

      d_gnt  <= d_sel;
      d_hold <= m_d_valid && !m_d_ready;
      if (d_hs) begin
        if (d_lock) begin
          d_cnt <= d_cnt - 8'd1;
          if (d_cnt == 8'd1) d_lock <= 1'b0;
        end else if (d_first_burst) begin
          d_lock <= 1'b1;
          d_cnt  <= d_beats - 8'd1;
        end
        if (d_last) rr <= rr_next;
      end
    end
  end

endmodule
